// File: rtl/maze_pkg.sv
// Maze geometry and the tag type that travels alongside each ROM lookup.
package maze_pkg;
  localparam int unsigned TILE_WIDTH  = 17;
  localparam int unsigned TILE_HEIGHT = 15;
  localparam int unsigned MAZE_COLS   = 28;
  localparam int unsigned MAZE_ROWS   = 31;
  localparam int unsigned TAG_ID_W    = 3;

  typedef logic [4:0] tile_idx_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
    logic                oob;
  } lookup_tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first eligible requester at or after a rotating pointer.
// The pointer advances past each winner and holds when nothing is eligible.
module rr_arbiter #(
  parameter int unsigned N  = 8,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  eligible,
  output logic          grant_vld,
  output logic [PW-1:0] grant_id
);
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW:0]   idx;

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (!grant_vld && eligible[idx[PW-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = idx[PW-1:0];
      end
    end
  end

  // Explicit wrap so non-power-of-two requester counts work.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) ptr_d = (grant_id == PW'(N-1)) ? '0 : grant_id + PW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end
endmodule

// File: rtl/maze_lookup_arb.sv
// Shares one synchronous maze-wall ROM port between all tile-wall requesters,
// one round-robin grant per clock, with a per-requester req/ack handshake.
module maze_lookup_arb #(
  parameter int unsigned NUM_REQ     = 8,
  parameter int unsigned ROW_W       = 5,
  parameter int unsigned COL_W       = 5,
  parameter int unsigned MAZE_ROWS   = 31,
  parameter int unsigned MAZE_COLS   = 28,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*ROW_W-1:0] req_row,
  input  logic [NUM_REQ*COL_W-1:0] req_col,
  output logic [NUM_REQ-1:0]       ack,
  output logic [NUM_REQ-1:0]       rsp_wall,
  output logic                     rom_en,
  output logic [ROW_W-1:0]         rom_row,
  output logic [COL_W-1:0]         rom_col,
  input  logic                     rom_wall,
  output logic                     busy
);
  import maze_pkg::*;

  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] inflight_q, inflight_d, eligible, grant_hot, exit_hot;
  logic [NUM_REQ-1:0] ack_q, rsp_wall_q, rsp_wall_d;
  logic               grant_vld, sel_oob, rom_en_q;
  logic [IDW-1:0]     grant_id;
  logic [ROW_W-1:0]   sel_row, rom_row_q;
  logic [COL_W-1:0]   sel_col, rom_col_q;
  lookup_tag_t        tag_q [ROM_LATENCY+1];
  lookup_tag_t        tag_new, tag_exit;

  assign eligible = req & ~inflight_q;

  rr_arbiter #(.N(NUM_REQ), .PW(IDW)) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .eligible  (eligible),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  always_comb begin
    grant_hot = '0;
    sel_row   = '0;
    sel_col   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_vld && grant_id == IDW'(i)) begin
        grant_hot[i] = 1'b1;
        sel_row      = req_row[i*ROW_W +: ROW_W];
        sel_col      = req_col[i*COL_W +: COL_W];
      end
    end
  end

  assign sel_oob  = (sel_row >= ROW_W'(MAZE_ROWS)) || (sel_col >= COL_W'(MAZE_COLS));
  assign tag_new  = '{valid: grant_vld, id: TAG_ID_W'(grant_id), oob: sel_oob};
  assign tag_exit = tag_q[ROM_LATENCY];

  // Off-maze tiles never touch the ROM but still answer "wall" on the normal schedule.
  always_comb begin
    exit_hot   = '0;
    rsp_wall_d = rsp_wall_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (tag_exit.valid && tag_exit.id == TAG_ID_W'(i)) begin
        exit_hot[i]   = 1'b1;
        rsp_wall_d[i] = tag_exit.oob | rom_wall;
      end
    end
  end

  assign inflight_d = (inflight_q | grant_hot) & ~exit_hot;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= '0;
      ack_q      <= '0;
      rsp_wall_q <= '1;
      rom_en_q   <= 1'b0;
      rom_row_q  <= '0;
      rom_col_q  <= '0;
      for (int unsigned k = 0; k <= ROM_LATENCY; k++) tag_q[k] <= '0;
    end else begin
      inflight_q <= inflight_d;
      ack_q      <= exit_hot;
      rsp_wall_q <= rsp_wall_d;
      rom_en_q   <= grant_vld & ~sel_oob;
      if (grant_vld && !sel_oob) begin
        rom_row_q <= sel_row;
        rom_col_q <= sel_col;
      end
      tag_q[0] <= tag_new;
      for (int unsigned k = 1; k <= ROM_LATENCY; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign ack      = ack_q;
  assign rsp_wall = rsp_wall_q;
  assign rom_en   = rom_en_q;
  assign rom_row  = rom_row_q;
  assign rom_col  = rom_col_q;
  assign busy     = |inflight_q;
endmodule

// File: tb/tb_maze_lookup_arb.sv
// Bench for maze_lookup_arb: lookup table, directed multi-cycle sequences,
// and random traffic against a transaction-level model with a border-wall ROM.
module tb_maze_lookup_arb;
  localparam int NR = 8;
  localparam int RW = 5;
  localparam int CW = 5;
  localparam int L  = 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NR-1:0] req = '0;
  logic [NR*RW-1:0] req_row = '0;
  logic [NR*CW-1:0] req_col = '0;
  logic [NR-1:0] ack, rsp_wall;
  logic          rom_en, rom_wall, busy;
  logic [RW-1:0] rom_row;
  logic [CW-1:0] rom_col;

  int checks = 0;
  int errors = 0;

  always #20 clk = ~clk;

  maze_lookup_arb #(.NUM_REQ(NR), .ROW_W(RW), .COL_W(CW), .MAZE_ROWS(31),
                    .MAZE_COLS(28), .ROM_LATENCY(L)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_row(req_row), .req_col(req_col),
    .ack(ack), .rsp_wall(rsp_wall), .rom_en(rom_en), .rom_row(rom_row),
    .rom_col(rom_col), .rom_wall(rom_wall), .busy(busy)
  );

  function automatic bit ref_wall(int r, int c);
    if (r >= 31 || c >= 28) return 1'b1;
    return (r == 0) || (c == 0) || (r == 30) || (c == 27);
  endfunction

  // External ROM: data for the address sampled at an edge appears L clocks later.
  logic rom_pipe [L];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_en ? ref_wall(int'(rom_row), int'(rom_col)) : 1'b0;
    for (int k = 1; k < L; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign rom_wall = rom_pipe[L-1];

  // Transaction model: each grant is due L+1 edges later.
  int      m_ptr, m_cyc, m_win, m_r, m_c;
  bit      m_out  [NR];
  int      m_due  [NR];
  bit      m_wall [NR];
  logic [NR-1:0] e_ack, e_wall;
  logic    e_rom_en;
  int      e_row, e_col;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ptr = 0; m_cyc = 0; e_ack = '0; e_wall = '1; e_rom_en = 1'b0; e_row = 0; e_col = 0;
      for (int i = 0; i < NR; i++) begin m_out[i] = 1'b0; m_due[i] = 0; m_wall[i] = 1'b1; end
    end else begin
      m_cyc++;
      m_win = -1;
      for (int k = 0; k < NR; k++)
        if (m_win < 0 && req[(m_ptr + k) % NR] && !m_out[(m_ptr + k) % NR]) m_win = (m_ptr + k) % NR;
      e_ack = '0;
      for (int i = 0; i < NR; i++)
        if (m_out[i] && m_due[i] == m_cyc) begin
          e_ack[i] = 1'b1; e_wall[i] = m_wall[i]; m_out[i] = 1'b0;
        end
      e_rom_en = 1'b0;
      if (m_win >= 0) begin
        m_r = int'(req_row[m_win*RW +: RW]);
        m_c = int'(req_col[m_win*CW +: CW]);
        m_out[m_win] = 1'b1; m_due[m_win] = m_cyc + L + 1;
        m_wall[m_win] = ref_wall(m_r, m_c);
        m_ptr = (m_win + 1) % NR;
        if (m_r < 31 && m_c < 28) begin e_rom_en = 1'b1; e_row = m_r; e_col = m_c; end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_rc(input int i, input int r, input int c);
    req_row[i*RW +: RW] = RW'(r);
    req_col[i*CW +: CW] = CW'(c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic single_lookup(input int id, input int r, input int c, input bit w, input bit en);
    @(negedge clk);
    set_rc(id, r, c);
    req = NR'(1) << id;
    @(negedge clk);
    chk("rom_en", rom_en, en);
    if (en) begin chk("rom_row", rom_row, r); chk("rom_col", rom_col, c); end
    chk("busy_set", busy, 1);
    req = '0;
    for (int k = 1; k <= L; k++) begin @(negedge clk); chk("ack_early", ack, 0); end
    @(negedge clk);
    chk("ack", ack, NR'(1) << id);
    chk("rsp_wall", rsp_wall[id], w);
    @(negedge clk);
    chk("ack_pulse", ack, 0);
    chk("busy_clr", busy, 0);
  endtask

  typedef struct { int id; int row; int col; bit wall; bit en; } vec_t;
  vec_t tbl [8];

  initial begin
    logic [NR-1:0] ea;
    logic          exp_busy;
    tbl[0] = '{2,  5,  5, 1'b0, 1'b1};
    tbl[1] = '{4, 31,  3, 1'b1, 1'b0};
    tbl[2] = '{0,  1,  1, 1'b0, 1'b1};
    tbl[3] = '{7, 30, 10, 1'b1, 1'b1};
    tbl[4] = '{3, 10, 27, 1'b1, 1'b1};
    tbl[5] = '{5, 10, 28, 1'b1, 1'b0};
    tbl[6] = '{6,  0, 15, 1'b1, 1'b1};
    tbl[7] = '{1, 15, 26, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_wall", rsp_wall, 8'hFF);
    chk("rst_rom_en", rom_en, 0);
    chk("rst_rom_addr", {rom_row, rom_col}, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;

    foreach (tbl[n]) single_lookup(tbl[n].id, tbl[n].row, tbl[n].col, tbl[n].wall, tbl[n].en);

    // All eight requesters at once from ptr 0: grants and acks in index order.
    do_reset();
    for (int i = 0; i < NR; i++) set_rc(i, 0, 3);
    req = '1;
    for (int c = 0; c <= 7 + L + 1; c++) begin
      @(negedge clk);
      chk("all_rom_en", rom_en, c <= 7);
      if (c <= 7) chk("all_rom_col", rom_col, 3);
      ea = (c >= L + 1 && c - (L + 1) <= 7) ? NR'(1) << (c - L - 1) : '0;
      chk("all_ack_order", ack, ea);
      if (c == 7) req = '0;
    end
    @(negedge clk);
    chk("all_wall", rsp_wall, 8'hFF);
    chk("all_busy", busy, 0);
    // Pointer wrapped to 0: requester 0 beats requester 7.
    set_rc(0, 5, 5); set_rc(7, 5, 5);
    req = 8'h81;
    @(negedge clk); @(negedge clk);
    req = '0;
    for (int c = 2; c <= L + 2; c++) begin
      @(negedge clk);
      ea = (c == L + 1) ? 8'h01 : (c == L + 2) ? 8'h80 : 8'h00;
      chk("wrap_ack", ack, ea);
    end

    // Pointer at 3 with requesters 1 and 6: 6 wins first.
    do_reset();
    single_lookup(2, 5, 5, 1'b0, 1'b1);
    @(negedge clk);
    set_rc(1, 5, 5); set_rc(6, 5, 5);
    req = 8'h42;
    for (int c = 0; c <= L + 2; c++) begin
      @(negedge clk);
      ea = (c == L + 1) ? 8'h40 : (c == L + 2) ? 8'h02 : 8'h00;
      chk("rr_ack", ack, ea);
      if (c == 1) req = '0;
    end

    // Reset one cycle after a grant discards the lookup.
    @(negedge clk);
    set_rc(3, 5, 5);
    req = 8'h08;
    @(negedge clk);
    chk("pre_rst_rom_en", rom_en, 1);
    req = '0;
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < L + 3; c++) begin
      @(negedge clk);
      chk("no_late_ack", ack, 0);
    end
    chk("post_rst_wall", rsp_wall, 8'hFF);
    chk("post_rst_busy", busy, 0);
    single_lookup(3, 5, 5, 1'b0, 1'b1);

    // Requester 0 held high: a lookup every L+2 cycles, never overlapping.
    @(negedge clk);
    set_rc(0, 1, 1);
    req = 8'h01;
    for (int c = 0; c < 4 * (L + 2); c++) begin
      @(negedge clk);
      chk("hold_ack", ack, (c % (L + 2) == L + 1) ? 8'h01 : 8'h00);
      chk("hold_rom_en", rom_en, c % (L + 2) == 0);
      chk("hold_busy", busy, c % (L + 2) != L + 1);
    end
    req = '0;
    repeat (L + 3) @(negedge clk);
    chk("hold_idle", busy, 0);
    chk("hold_wall", rsp_wall[0], 0);

    // Random traffic against the model.
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      exp_busy = 1'b0;
      for (int i = 0; i < NR; i++) exp_busy |= m_out[i];
      chk("rnd_ack", ack, e_ack);
      chk("rnd_wall", rsp_wall, e_wall);
      chk("rnd_busy", busy, exp_busy);
      chk("rnd_rom_en", rom_en, e_rom_en);
      if (e_rom_en) begin
        chk("rnd_rom_row", rom_row, e_row);
        chk("rnd_rom_col", rom_col, e_col);
      end
      for (int i = 0; i < NR; i++) begin
        req[i] = ($urandom_range(0, 3) != 0);
        if (!m_out[i]) set_rc(i, $urandom_range(0, 31), $urandom_range(0, 31));
      end
    end
    req = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
